// File: rtl/vend_pkg.sv
// Shared vending definitions: coin denominations, coin_type encoding and the
// change dispenser state encoding.
package vend_pkg;

    localparam int DENOM_20 = 20;
    localparam int DENOM_10 = 10;
    localparam int DENOM_5  = 5;
    localparam int DENOM_1  = 1;

    // Encoding order doubles as selection priority: lower code = larger coin.
    typedef enum logic [1:0] {
        COIN_20 = 2'd0,
        COIN_10 = 2'd1,
        COIN_5  = 2'd2,
        COIN_1  = 2'd3
    } coin_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_EMIT,
        ST_GAP,
        ST_DONE
    } disp_state_t;

    function automatic int coin_value(input coin_t c);
        case (c)
            COIN_20: return DENOM_20;
            COIN_10: return DENOM_10;
            COIN_5:  return DENOM_5;
            default: return DENOM_1;
        endcase
    endfunction

endpackage

// File: rtl/coin_select.sv
// Combinational greedy picker: largest denomination that fits the remaining
// amount and still has coins in stock.
module coin_select
    import vend_pkg::*;
#(
    parameter int AMT_W = 7
) (
    input  logic [AMT_W-1:0] remaining,
    input  logic [3:0]       nonzero,
    output logic             found,
    output coin_t            coin_type,
    output logic [AMT_W-1:0] value
);

    always_comb begin
        found     = 1'b0;
        coin_type = COIN_20;
        value     = '0;
        // Walk smallest to largest so the largest eligible coin is written last.
        for (int i = 3; i >= 0; i--) begin
            if (nonzero[i] && (AMT_W'(coin_value(coin_t'(i[1:0]))) <= remaining)) begin
                found     = 1'b1;
                coin_type = coin_t'(i[1:0]);
                value     = AMT_W'(coin_value(coin_t'(i[1:0])));
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays a change amount as individual coin pulses from a finite inventory.
// Optional CHANGE_AUDIT_EN adds a saturating total_paid counter output.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W      = 7,
    parameter int INV_W      = 8,
    parameter int INIT_COUNT = 20,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             change_valid,
    input  logic [AMT_W-1:0] change_amount,
    output logic             change_ready,
    input  logic             refill,
    output logic             coin_out,
    output logic [1:0]       coin_type,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] shortfall,
    output logic [3:0]       inv_empty
`ifdef CHANGE_AUDIT_EN
    ,
    output logic [15:0]      total_paid
`endif
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    disp_state_t      state, state_next;
    logic [AMT_W-1:0] remaining;
    logic [AMT_W-1:0] pay_value;
    coin_t            coin_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [INV_W-1:0] inv [4];
    logic [3:0]       nonzero;
    logic             sel_found;
    coin_t            sel_type;
    logic [AMT_W-1:0] sel_value;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nonzero[i] = (inv[i] != '0);
        end
    end

    assign inv_empty    = ~nonzero;
    assign change_ready = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign coin_out     = (state == ST_EMIT);
    assign done         = (state == ST_DONE);
    assign coin_type    = coin_q;

    coin_select #(.AMT_W(AMT_W)) u_select (
        .remaining (remaining),
        .nonzero   (nonzero),
        .found     (sel_found),
        .coin_type (sel_type),
        .value     (sel_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (change_valid) state_next = ST_SELECT;
            ST_SELECT: state_next = sel_found ? ST_EMIT : ST_DONE;
            ST_EMIT:   state_next = ST_GAP;
            ST_GAP:    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_next = ST_SELECT;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Refill is applied before the accept lands, so a coincident payout sees full stock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            pay_value <= '0;
            coin_q    <= COIN_20;
            gap_cnt   <= '0;
            shortfall <= '0;
            for (int i = 0; i < 4; i++) begin
                inv[i] <= INV_W'(INIT_COUNT);
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (refill) begin
                        for (int i = 0; i < 4; i++) begin
                            inv[i] <= INV_W'(INIT_COUNT);
                        end
                    end
                    if (change_valid) begin
                        remaining <= change_amount;
                        shortfall <= '0;
                    end
                end
                ST_SELECT: begin
                    if (sel_found) begin
                        coin_q    <= sel_type;
                        pay_value <= sel_value;
                    end else begin
                        shortfall <= remaining;
                    end
                end
                ST_EMIT: begin
                    remaining <= remaining - pay_value;
                    if (inv[coin_q] != '0) begin
                        inv[coin_q] <= inv[coin_q] - INV_W'(1);
                    end
                    gap_cnt <= '0;
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef CHANGE_AUDIT_EN
    logic [16:0] paid_sum;

    assign paid_sum = {1'b0, total_paid} + 17'(pay_value);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_paid <= '0;
        end else if (state == ST_EMIT) begin
            total_paid <= paid_sum[16] ? 16'hFFFF : paid_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus random
// payouts checked against a greedy coin-inventory model.
module tb_change_dispenser;

    localparam int AMT_W      = 7;
    localparam int INV_W      = 8;
    localparam int INIT_COUNT = 20;
    localparam int GAP_CYCLES = 1;
    localparam int BUDGET     = 600;

    logic             clk;
    logic             rst_n;
    logic             change_valid;
    logic [AMT_W-1:0] change_amount;
    logic             change_ready;
    logic             refill;
    logic             coin_out;
    logic [1:0]       coin_type;
    logic             busy;
    logic             done;
    logic [AMT_W-1:0] shortfall;
    logic [3:0]       inv_empty;
`ifdef CHANGE_AUDIT_EN
    logic [15:0]      total_paid;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: coin values by coin_type, stock per coin_type, money paid.
    int den[4] = '{20, 10, 5, 1};
    int inv_m[4];
    int total_m;

    change_dispenser #(
        .AMT_W(AMT_W), .INV_W(INV_W), .INIT_COUNT(INIT_COUNT), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .change_valid  (change_valid),
        .change_amount (change_amount),
        .change_ready  (change_ready),
        .refill        (refill),
        .coin_out      (coin_out),
        .coin_type     (coin_type),
        .busy          (busy),
        .done          (done),
        .shortfall     (shortfall),
        .inv_empty     (inv_empty)
`ifdef CHANGE_AUDIT_EN
        ,
        .total_paid    (total_paid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] model_empty();
        logic [3:0] e;
        for (int i = 0; i < 4; i++) e[i] = (inv_m[i] == 0);
        return e;
    endfunction

    task automatic model_reload();
        for (int i = 0; i < 4; i++) inv_m[i] = INIT_COUNT;
    endtask

    task automatic check_idle_state(input string tag, input logic [AMT_W-1:0] exp_short);
        checks++;
        if (change_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || coin_out !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: ready=%b busy=%b done=%b coin=%b expected 1 0 0 0",
                     tag, change_ready, busy, done, coin_out);
        end
        checks++;
        if (shortfall !== exp_short) begin
            errors++;
            $display("FAIL %s shortfall: got %0d expected %0d", tag, shortfall, exp_short);
        end
        checks++;
        if (inv_empty !== model_empty()) begin
            errors++;
            $display("FAIL %s inv_empty: got %b expected %b", tag, inv_empty, model_empty());
        end
`ifdef CHANGE_AUDIT_EN
        checks++;
        if (total_paid !== 16'(total_m)) begin
            errors++;
            $display("FAIL %s total_paid: got %0d expected %0d", tag, total_paid, total_m);
        end
`endif
    endtask

    // One payout: poke injects valid(50)+refill at cycle 3; reset_cyc>0 pulls rst_n at that cycle.
    task automatic run_payout(input string tag, input int amt, input bit with_refill,
                              input bit poke, input int reset_cyc);
        logic [1:0]       exp_q[$];
        logic [1:0]       exp_t;
        logic [AMT_W-1:0] exp_short;
        int  rem, exp_done, coin_idx;
        bit  found, got_done, aborted;

        if (with_refill) model_reload();
        rem = amt;
        do begin
            found = 1'b0;
            for (int d = 0; d < 4; d++) begin
                if (!found && den[d] <= rem && inv_m[d] > 0) begin
                    found = 1'b1;
                    exp_q.push_back(2'(d));
                    rem -= den[d];
                    inv_m[d]--;
                    total_m = (total_m + den[d] > 65535) ? 65535 : total_m + den[d];
                end
            end
        end while (found);
        exp_short = AMT_W'(rem);
        exp_done  = 2 + exp_q.size() * (GAP_CYCLES + 2);

        @(negedge clk);
        change_valid  = 1'b1;
        change_amount = AMT_W'(amt);
        refill        = with_refill;
        got_done = 1'b0;
        aborted  = 1'b0;
        coin_idx = 0;
        for (int cyc = 1; cyc <= BUDGET && !got_done && !aborted; cyc++) begin
            @(negedge clk);
            change_valid = 1'b0;
            refill       = 1'b0;
            if (poke && cyc == 3) begin
                change_valid  = 1'b1;
                change_amount = AMT_W'(50);
                refill        = 1'b1;
            end
            if (cyc == reset_cyc) begin
                rst_n = 1'b0;
                #1;
                aborted = 1'b1;
                checks++;
                if (coin_out !== 1'b0 || done !== 1'b0 || change_ready !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s reset: coin=%b done=%b ready=%b busy=%b expected 0 0 1 0",
                             tag, coin_out, done, change_ready, busy);
                end
            end else begin
                checks++;
                if (busy !== 1'b1 || change_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy cyc %0d: busy=%b ready=%b expected 1 0",
                             tag, cyc, busy, change_ready);
                end
                if (coin_out === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL %s extra coin cyc %0d: type %0d expected none", tag, cyc, coin_type);
                    end else begin
                        exp_t = exp_q.pop_front();
                        if (coin_type !== exp_t || cyc != 2 + coin_idx * (GAP_CYCLES + 2)) begin
                            errors++;
                            $display("FAIL %s coin %0d: type %0d at cyc %0d expected type %0d at cyc %0d",
                                     tag, coin_idx, coin_type, cyc, exp_t,
                                     2 + coin_idx * (GAP_CYCLES + 2));
                        end
                    end
                    coin_idx++;
                end
                if (done === 1'b1) begin
                    got_done = 1'b1;
                    checks++;
                    if (cyc != exp_done || shortfall !== exp_short || exp_q.size() != 0) begin
                        errors++;
                        $display("FAIL %s done: cyc %0d short %0d missing %0d expected cyc %0d short %0d missing 0",
                                 tag, cyc, shortfall, exp_q.size(), exp_done, exp_short);
                    end
                end
            end
        end

        if (aborted) begin
            model_reload();
            total_m = 0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check_idle_state({tag, "_after_reset"}, '0);
        end else if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles expected done at cyc %0d",
                     tag, BUDGET, exp_done);
            change_valid = 1'b0;
            refill       = 1'b0;
        end else begin
            @(negedge clk);
            check_idle_state(tag, exp_short);
            // A poke during busy must not start a second payout.
            repeat (3) @(negedge clk);
            checks++;
            if (busy !== 1'b0 || coin_out !== 1'b0) begin
                errors++;
                $display("FAIL %s stray start: busy=%b coin=%b expected 0 0", tag, busy, coin_out);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        model_reload();
        total_m = 0;
        check_idle_state("reset", '0);
        checks++;
        if (coin_type !== 2'd0) begin
            errors++;
            $display("FAIL reset coin_type: got %0d expected 0", coin_type);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_state("reset_release", '0);
    endtask

    task automatic test_basic();
        run_payout("pay35", 35, 1'b0, 1'b0, 0);
        run_payout("pay47", 47, 1'b0, 1'b0, 0);
    endtask

    task automatic test_zero();
        run_payout("pay0", 0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_busy_ignore();
        run_payout("busy_poke15", 15, 1'b0, 1'b1, 0);
    endtask

    task automatic test_reset_mid_payout();
        run_payout("reset_gap35", 35, 1'b0, 1'b0, 3);
        run_payout("pay35_post_reset", 35, 1'b0, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_payout("rand", int'($urandom_range(0, 127)), ($urandom_range(0, 7) == 0), 1'b0, 0);
        end
    endtask

    task automatic test_deplete();
        for (int n = 0; n < 10; n++) begin
            run_payout("deplete127", 127, 1'b0, 1'b0, 0);
        end
    endtask

    task automatic test_refill_idle();
        @(negedge clk);
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        model_reload();
        checks++;
        if (inv_empty !== model_empty()) begin
            errors++;
            $display("FAIL refill_idle inv_empty: got %b expected %b", inv_empty, model_empty());
        end
    endtask

    task automatic test_refill_with_accept();
        test_deplete();
        run_payout("refill_accept35", 35, 1'b1, 1'b0, 0);
    endtask

    initial begin
        change_valid  = 1'b0;
        change_amount = '0;
        refill        = 1'b0;
        rst_n         = 1'b0;
        total_m       = 0;
        model_reload();

        test_reset();
        test_basic();
        test_zero();
        test_busy_ignore();
        test_reset_mid_payout();
        test_random();
        test_deplete();
        test_refill_idle();
        test_refill_with_accept();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
